// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC receive path.
package hdlc_pkg;

  // Per-bit classification produced by the line classifier.
  typedef enum logic [2:0] {
    NONE,
    DATA0,
    DATA1,
    FLAG,
    ABORT
  } hdlc_evt_e;

  // Framer FSM states.
  typedef enum logic {
    HUNT,
    OPEN
  } hdlc_rx_state_e;

  // Ones-run lengths that give a special meaning to the following bit.
  localparam logic [2:0] ONES_STUFF = 3'd5;
  localparam logic [2:0] ONES_FLAG  = 3'd6;
  localparam logic [2:0] ONES_ABORT = 3'd7;

endpackage

// File: rtl/hdlc_bit_classifier.sv
// Ones-run counter and per-bit event decode. The event is combinational
// from the current bit so the framer can register its outputs on the
// same edge that samples the bit.
module hdlc_bit_classifier
  import hdlc_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      in,
  input  logic      in_valid,
  output hdlc_evt_e evt
);

  logic [2:0] c_q, c_d, c_inc;

  // Next run length and event for the bit currently on the line.
  always_comb begin
    c_inc = (c_q == ONES_ABORT) ? c_q : c_q + 3'd1;
    c_d   = c_q;
    evt   = NONE;
    if (in_valid) begin
      if (in) begin
        c_d = c_inc;
        if (c_inc <= ONES_STUFF) begin
          evt = DATA1;
        end else if ((c_inc == ONES_ABORT) && (c_q == ONES_FLAG)) begin
          // Only the 6->7 step aborts; longer runs stay saturated and silent.
          evt = ABORT;
        end
      end else begin
        c_d = '0;
        case (c_q)
          ONES_STUFF: evt = NONE;
          ONES_FLAG:  evt = FLAG;
          ONES_ABORT: evt = NONE;
          default:    evt = DATA0;
        endcase
      end
    end
  end

  // Run-length register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) c_q <= '0;
    else       c_q <= c_d;
  end

endmodule

// File: rtl/hdlc_rx_framer.sv
// HDLC receive framer: hunt/open FSM, LSB-first byte assembly, byte
// counting and frame status toward the downstream frame buffer.
module hdlc_rx_framer
  import hdlc_pkg::*;
#(
  parameter int MAX_BYTES = 64,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_err,
  output logic             frame_abort
);

  localparam logic [LEN_W-1:0] MAX_BYTES_L = LEN_W'(MAX_BYTES);

  hdlc_evt_e      evt;
  hdlc_rx_state_e state_q, state_d;
  // Last seven data bits; the eighth comes straight from the line.
  logic [6:0]       sr_q, sr_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [LEN_W-1:0] bytecnt_q, bytecnt_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             frame_err_q, frame_err_d;
  logic             frame_abort_q, frame_abort_d;
  logic [7:0]       byte_next;

  hdlc_bit_classifier u_classifier (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .in_valid (in_valid),
    .evt      (evt)
  );

  // FSM, shifter and counter next-state; pulses default low every cycle.
  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    bitcnt_d      = bitcnt_q;
    bytecnt_d     = bytecnt_q;
    ovf_d         = ovf_q;
    byte_data_d   = byte_data_q;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    frame_len_d   = frame_len_q;
    frame_err_d   = frame_err_q;
    frame_abort_d = 1'b0;
    byte_next     = {(evt == DATA1), sr_q};

    if (state_q == HUNT) begin
      if (evt == FLAG) begin
        state_d   = OPEN;
        bitcnt_d  = '0;
        bytecnt_d = '0;
        ovf_d     = 1'b0;
      end
    end else begin
      case (evt)
        DATA0, DATA1: begin
          sr_d     = byte_next[7:1];
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            if (bytecnt_q < MAX_BYTES_L) begin
              byte_valid_d  = 1'b1;
              byte_data_d   = byte_next;
              frame_start_d = (bytecnt_q == '0);
              bytecnt_d     = bytecnt_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        FLAG: begin
          // The closing flag's leading 0 and five 1s were shifted in as
          // data, so a byte-aligned frame ends with exactly 6 residual bits.
          if (bytecnt_q != '0) begin
            frame_end_d = 1'b1;
            frame_len_d = bytecnt_q;
            frame_err_d = (bitcnt_q != 3'd6) | ovf_q;
          end
          bitcnt_d  = '0;
          bytecnt_d = '0;
          ovf_d     = 1'b0;
        end
        ABORT: begin
          frame_abort_d = (bytecnt_q != '0) || (bitcnt_q != '0);
          bitcnt_d      = '0;
          bytecnt_d     = '0;
          ovf_d         = 1'b0;
          state_d       = HUNT;
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      sr_q          <= '0;
      bitcnt_q      <= '0;
      bytecnt_q     <= '0;
      ovf_q         <= 1'b0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_len_q   <= '0;
      frame_err_q   <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      bitcnt_q      <= bitcnt_d;
      bytecnt_q     <= bytecnt_d;
      ovf_q         <= ovf_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frame_len_q   <= frame_len_d;
      frame_err_q   <= frame_err_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign frame_len   = frame_len_q;
  assign frame_err   = frame_err_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_hdlc_rx_framer.sv
// Bench for hdlc_rx_framer: a 64-byte and a 4-byte instance share one
// serial stream; expected events are queued per instance and popped by
// a monitor whenever an instance pulses an output.
module tb_hdlc_rx_framer;

  localparam int K_BYTE  = 0;
  localparam int K_END   = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    int kind;
    int data;
    int start;
    int len;
    int err;
  } exp_t;

  typedef struct {
    int          nbytes;
    logic [39:0] payload;
    int          nextra;
    logic [1:0]  extra;
    bit          gaps;
    int          len64;
    int          err64;
    int          len4;
    int          err4;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic ser;
  logic in_valid;

  logic [7:0] bd64, bd4;
  logic       bv64, fs64, fe64, ferr64, fa64;
  logic       bv4, fs4, fe4, ferr4, fa4;
  logic [6:0] fl64;
  logic [2:0] fl4;

  int   checks = 0;
  int   errors = 0;
  int   tx_ones = 0;
  exp_t q64[$];
  exp_t q4[$];
  vec_t vec[6];

  always #5 clk = ~clk;

  hdlc_rx_framer #(.MAX_BYTES(64)) dut (
    .clk(clk), .reset(reset), .in(ser), .in_valid(in_valid),
    .byte_data(bd64), .byte_valid(bv64), .frame_start(fs64), .frame_end(fe64),
    .frame_len(fl64), .frame_err(ferr64), .frame_abort(fa64)
  );

  hdlc_rx_framer #(.MAX_BYTES(4)) dut4 (
    .clk(clk), .reset(reset), .in(ser), .in_valid(in_valid),
    .byte_data(bd4), .byte_valid(bv4), .frame_start(fs4), .frame_end(fe4),
    .frame_len(fl4), .frame_err(ferr4), .frame_abort(fa4)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int mask, input int kind, input int data,
                      input int start, input int len, input int err);
    exp_t e;
    e.kind = kind; e.data = data; e.start = start; e.len = len; e.err = err;
    if (mask[0]) q64.push_back(e);
    if (mask[1]) q4.push_back(e);
  endtask

  task automatic pop(input int which, output exp_t e, output int ok);
    ok = 0;
    e  = '{default: 0};
    if (which == 0) begin
      if (q64.size() > 0) begin e = q64.pop_front(); ok = 1; end
    end else begin
      if (q4.size() > 0) begin e = q4.pop_front(); ok = 1; end
    end
  endtask

  task automatic mon(input int which, input logic bv, input logic [7:0] bd,
                     input logic fs, input logic fe, input int fl,
                     input logic fer, input logic fa);
    exp_t e;
    int   ok;
    if (fs && !bv) chk($sformatf("start_without_byte%0d", which), 1, 0);
    if (bv) begin
      pop(which, e, ok);
      chk($sformatf("byte_expected%0d", which), ok, 1);
      if (ok != 0) begin
        chk($sformatf("byte_kind%0d", which), K_BYTE, e.kind);
        chk($sformatf("byte_data%0d", which), int'(bd), e.data);
        chk($sformatf("frame_start%0d", which), int'(fs), e.start);
      end
    end
    if (fe) begin
      pop(which, e, ok);
      chk($sformatf("end_expected%0d", which), ok, 1);
      if (ok != 0) begin
        chk($sformatf("end_kind%0d", which), K_END, e.kind);
        chk($sformatf("frame_len%0d", which), fl, e.len);
        chk($sformatf("frame_err%0d", which), int'(fer), e.err);
      end
    end
    if (fa) begin
      pop(which, e, ok);
      chk($sformatf("abort_expected%0d", which), ok, 1);
      if (ok != 0) chk($sformatf("abort_kind%0d", which), K_ABORT, e.kind);
    end
  endtask

  // Outputs change on posedge; sample them on the opposite edge.
  always @(negedge clk) begin
    if (!reset) begin
      mon(0, bv64, bd64, fs64, fe64, int'(fl64), ferr64, fa64);
      mon(1, bv4, bd4, fs4, fe4, int'(fl4), ferr4, fa4);
    end
  end

  task automatic send_bit(input logic b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        ser      = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk); #1;
    ser      = b;
    in_valid = 1'b1;
  endtask

  task automatic send_data(input logic b, input bit gaps);
    send_bit(b, gaps);
    if (b) tx_ones++; else tx_ones = 0;
    if (tx_ones == 5) begin
      send_bit(1'b0, gaps);
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gaps);
    for (int i = 0; i < 8; i++) send_data(v[i], gaps);
  endtask

  task automatic send_flag(input bit gaps);
    send_bit(1'b0, gaps);
    repeat (6) send_bit(1'b1, gaps);
    send_bit(1'b0, gaps);
    tx_ones = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_q64_left"}, q64.size(), 0);
    chk({tag, "_q4_left"}, q4.size(), 0);
  endtask

  // Bytes a frame should deliver: payload and extra bits followed by the
  // closing flag's 0 and five 1s, cut into whole LSB-first bytes.
  task automatic expect_frame(input vec_t v);
    logic bits[$];
    int   nfull;
    int   b;
    for (int i = 0; i < v.nbytes * 8; i++) bits.push_back(v.payload[i]);
    for (int i = 0; i < v.nextra; i++) bits.push_back(v.extra[i]);
    bits.push_back(1'b0);
    repeat (5) bits.push_back(1'b1);
    nfull = bits.size() / 8;
    for (int k = 0; k < nfull; k++) begin
      b = 0;
      for (int j = 0; j < 8; j++) if (bits[8*k + j]) b |= (1 << j);
      push((k < 64 ? 1 : 0) | (k < 4 ? 2 : 0), K_BYTE, b, (k == 0) ? 1 : 0, 0, 0);
    end
    push(1, K_END, 0, 0, v.len64, v.err64);
    push(2, K_END, 0, 0, v.len4, v.err4);
  endtask

  initial begin
    //          nb payload                 nx  extra  gaps len64 err64 len4 err4
    vec[0] = '{1, 40'h00_0000_00A5,        0, 2'b00, 1'b0, 1, 0, 1, 0};
    vec[1] = '{1, 40'h00_0000_00FF,        0, 2'b00, 1'b0, 1, 0, 1, 0};
    vec[2] = '{1, 40'h00_0000_00FF,        0, 2'b00, 1'b1, 1, 0, 1, 0};
    vec[3] = '{1, 40'h00_0000_005A,        2, 2'b01, 1'b0, 2, 1, 2, 1};
    vec[4] = '{5, 40'h55_4433_2211,        0, 2'b00, 1'b0, 5, 0, 4, 1};
    vec[5] = '{2, 40'h00_0000_7EFF,        0, 2'b00, 1'b1, 2, 0, 2, 0};

    reset    = 1'b1;
    ser      = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_byte_data", int'(bd64), 0);
    chk("rst_byte_valid", int'(bv64), 0);
    chk("rst_frame_start", int'(fs64), 0);
    chk("rst_frame_end", int'(fe64), 0);
    chk("rst_frame_len", int'(fl64), 0);
    chk("rst_frame_err", int'(ferr64), 0);
    chk("rst_frame_abort", int'(fa64), 0);
    chk("rst_byte_valid4", int'(bv4), 0);
    chk("rst_frame_len4", int'(fl4), 0);
    reset = 1'b0;

    // HUNT ignores data and aborts before any flag.
    send_byte(8'hA5, 1'b0);
    repeat (7) send_bit(1'b1, 1'b0);
    tx_ones = 0;
    idle(4);
    chk_drained("hunt");

    for (int t = 0; t < 6; t++) begin
      expect_frame(vec[t]);
      send_flag(vec[t].gaps);
      for (int i = 0; i < vec[t].nbytes; i++) send_byte(vec[t].payload[8*i +: 8], vec[t].gaps);
      for (int i = 0; i < vec[t].nextra; i++) send_data(vec[t].extra[i], vec[t].gaps);
      send_flag(vec[t].gaps);
      idle(4);
      chk_drained($sformatf("vec%0d", t));
      chk($sformatf("vec%0d_len_hold", t), int'(fl64), vec[t].len64);
      chk($sformatf("vec%0d_err_hold", t), int'(ferr64), vec[t].err64);
      chk($sformatf("vec%0d_len_hold4", t), int'(fl4), vec[t].len4);
    end

    // Abort an open frame, then recover through a flag that follows the
    // seven-ones run.
    push(3, K_BYTE, 8'h3C, 1, 0, 0);
    push(3, K_ABORT, 0, 0, 0, 0);
    send_flag(1'b0);
    send_byte(8'h3C, 1'b0);
    repeat (7) send_bit(1'b1, 1'b0);
    tx_ones = 0;
    idle(3);
    chk_drained("abort");
    push(3, K_BYTE, 8'h12, 1, 0, 0);
    push(3, K_END, 0, 0, 1, 0);
    send_flag(1'b0);
    send_byte(8'h12, 1'b0);
    send_flag(1'b0);
    idle(4);
    chk_drained("after_abort");

    // Two flags in a row: an idle flag and an empty frame, no output.
    send_flag(1'b0);
    send_flag(1'b0);
    idle(4);
    chk_drained("flag_flag");

    // Reset mid-frame: immediate clear, no end/abort, back to HUNT.
    push(3, K_BYTE, 8'h3C, 1, 0, 0);
    send_flag(1'b0);
    send_byte(8'h3C, 1'b0);
    send_data(1'b1, 1'b0);
    send_data(1'b0, 1'b0);
    send_data(1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("midrst_byte_valid", int'(bv64), 0);
    chk("midrst_frame_len", int'(fl64), 0);
    chk("midrst_frame_err", int'(ferr64), 0);
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    tx_ones = 0;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    idle(4);
    chk_drained("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
